// File: rtl/pq_sched_pkg.sv
// Shared types for the priority-queue command scheduler: op codes, FSM states
// and the command word carried through the FIFO.
package pq_sched_pkg;
  localparam int PQ_DW = 16;

  typedef enum logic [1:0] {ENQ = 2'd0, DEQ = 2'd1, REPL = 2'd2, RSVD = 2'd3} op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    op_t              op;
    logic [PQ_DW-1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/pq_cmd_fifo.sv
// Synchronous command FIFO (power-of-2 depth) with occupancy count, full and empty.
module pq_cmd_fifo
  import pq_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [CMD_W-1:0]         i_din,
  output logic [CMD_W-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/pq_cmd_scheduler.sv
// Paces queued ENQ/DEQ/REPL commands onto the BRAM priority-queue tree strobes.
// Define PQ_SCHED_STATS_EN to add issued/rejected saturating counters.
module pq_cmd_scheduler
  import pq_sched_pkg::*;
#(
  parameter int DATA_WIDTH = PQ_DW,
  parameter int CMD_DEPTH  = 4,
  parameter int ISSUE_GAP  = 25
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [1:0]            s_op,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_err,
  output logic                  t_wrt,
  output logic                  t_read,
  output logic [DATA_WIDTH-1:0] t_data,
  input  logic                  t_full,
  input  logic                  t_empty,
  input  logic [DATA_WIDTH-1:0] t_top,
`ifdef PQ_SCHED_STATS_EN
  output logic [31:0]           o_stat_issued,
  output logic [31:0]           o_stat_rejected,
`endif
  output logic                  o_busy
);
  localparam int GW = $clog2(ISSUE_GAP + 1);
  localparam logic [GW-1:0] GAP_LD = GW'(ISSUE_GAP - 1);

  state_t                   r_state;
  logic [GW-1:0]            r_gap;
  logic                     r_wrt, r_read, r_rvalid, r_rerr;
  logic [DATA_WIDTH-1:0]    r_tdata, r_rdata;
  cmd_t                     w_in, w_head;
  logic [CMD_W-1:0]         w_head_bits;
  logic                     w_full, w_empty, w_go, w_wrt, w_rd;
  logic [$clog2(CMD_DEPTH):0] w_count;

  assign w_in.op   = op_t'(s_op);
  assign w_in.data = s_data;
  assign w_head    = cmd_t'(w_head_bits);

  pq_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (s_valid & s_ready),
    .i_pop   (w_go),
    .i_din   (w_in),
    .o_dout  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_go = (r_state == IDLE) & ~w_empty & (r_gap == '0) & ~r_rvalid;

  // Strobe decode from the head entry and the tree flags of the decision cycle.
  always_comb begin
    w_wrt = 1'b0;
    w_rd  = 1'b0;
    case (w_head.op)
      ENQ:     w_wrt = ~t_full;
      DEQ:     w_rd  = ~t_empty;
      REPL: begin
        w_wrt = 1'b1;
        w_rd  = ~t_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_gap    <= '0;
      r_wrt    <= 1'b0;
      r_read   <= 1'b0;
      r_tdata  <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rerr   <= 1'b0;
    end else begin
      r_wrt   <= 1'b0;
      r_read  <= 1'b0;
      r_tdata <= '0;
      if (w_go && (w_wrt || w_rd)) r_gap <= GAP_LD;
      else if (r_gap != '0)        r_gap <= r_gap - 1'b1;
      case (r_state)
        IDLE: if (w_go) begin
          r_state  <= ISSUE;
          r_wrt    <= w_wrt;
          r_read   <= w_rd;
          r_tdata  <= w_wrt ? w_head.data : '0;
          r_rvalid <= 1'b1;
          r_rdata  <= w_rd ? t_top : '0;
          r_rerr   <= ~(w_wrt | w_rd);
        end
        ISSUE, RESP: if (r_ready) begin
          r_state  <= IDLE;
          r_rvalid <= 1'b0;
        end else begin
          r_state  <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PQ_SCHED_STATS_EN
  logic [31:0] r_stat_iss, r_stat_rej;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stat_iss <= '0;
      r_stat_rej <= '0;
    end else if (w_go) begin
      if ((w_wrt | w_rd) && r_stat_iss != '1)    r_stat_iss <= r_stat_iss + 1'b1;
      if (!(w_wrt | w_rd) && r_stat_rej != '1)   r_stat_rej <= r_stat_rej + 1'b1;
    end
  end
  assign o_stat_issued   = RST ? '0 : r_stat_iss;
  assign o_stat_rejected = RST ? '0 : r_stat_rej;
`endif

  // Every output is forced low while reset is held, not just after the edge.
  assign s_ready = ~RST & ~w_full;
  assign r_valid = ~RST & r_rvalid;
  assign r_data  = RST ? '0 : r_rdata;
  assign r_err   = ~RST & r_rerr;
  assign t_wrt   = ~RST & r_wrt;
  assign t_read  = ~RST & r_read;
  assign t_data  = RST ? '0 : r_tdata;
  assign o_busy  = ~RST & ((w_count != '0) | r_rvalid | (r_gap != '0) | (r_state != IDLE));
endmodule

// File: tb/tb_pq_cmd_scheduler.sv
// Directed self-checking bench for pq_cmd_scheduler.
module tb_pq_cmd_scheduler;
  logic        CLK = 1'b0;
  logic        RST, s_valid, s_ready, r_valid, r_ready, r_err;
  logic        t_wrt, t_read, t_full, t_empty, o_busy;
  logic [1:0]  s_op;
  logic [15:0] s_data, r_data, t_data, t_top;
`ifdef PQ_SCHED_STATS_EN
  logic [31:0] o_stat_issued, o_stat_rejected;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stalls = 0;

  int          st_cyc[$], rs_cyc[$];
  logic        st_wrt[$], st_rd[$], rs_err[$];
  logic [15:0] st_data[$], rs_data[$];

  pq_cmd_scheduler dut (
    .CLK(CLK), .RST(RST), .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op),
    .s_data(s_data), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_err(r_err), .t_wrt(t_wrt), .t_read(t_read), .t_data(t_data),
    .t_full(t_full), .t_empty(t_empty), .t_top(t_top),
`ifdef PQ_SCHED_STATS_EN
    .o_stat_issued(o_stat_issued), .o_stat_rejected(o_stat_rejected),
`endif
    .o_busy(o_busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Record tree strobes and accepted responses with their cycle numbers.
  always @(negedge CLK) begin
    if (!RST) begin
      if (t_wrt || t_read) begin
        st_cyc.push_back(cyc); st_wrt.push_back(t_wrt);
        st_rd.push_back(t_read); st_data.push_back(t_data);
      end
      if (r_valid && r_ready) begin
        rs_cyc.push_back(cyc); rs_data.push_back(r_data); rs_err.push_back(r_err);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clr();
    st_cyc.delete(); st_wrt.delete(); st_rd.delete(); st_data.delete();
    rs_cyc.delete(); rs_data.delete(); rs_err.delete();
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] d, output int acc);
    int n = 0;
    s_valid = 1'b1; s_op = op; s_data = d;
    @(negedge CLK);
    if (!s_ready) stalls++;
    while (!s_ready && n < 200) begin @(negedge CLK); n++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready got 0 want 1");
    end
    acc = cyc;
    @(posedge CLK); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    int k = 0;
    while (rs_cyc.size() < n && k < 400) begin @(posedge CLK); k++; end
    #1;
    if (rs_cyc.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_resp: responses got %0d want %0d", rs_cyc.size(), n);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge CLK);
    while (o_busy && k < 200) begin @(negedge CLK); k++; end
    if (o_busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: o_busy got 1 want 0");
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({s_ready, r_valid, r_err, t_wrt, t_read, o_busy} !== 6'b0 || r_data !== 16'd0 || t_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: flags got %b want 000000", {s_ready, r_valid, r_err, t_wrt, t_read, o_busy});
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (s_ready !== 1'b1 || o_busy !== 1'b0 || r_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: s_ready/o_busy/r_valid got %b%b%b want 100", s_ready, o_busy, r_valid);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_enq_single();
    int acc;
    clr(); t_empty = 1'b1; t_full = 1'b0;
    send(2'd0, 16'd100, acc);
    wait_resp(1);
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (st_cyc.size() !== 1) begin
      errors++; $display("FAIL enq_strobe_count: got %0d want 1", st_cyc.size());
    end else begin
      checks++;
      if (st_cyc[0] !== acc + 2 || st_wrt[0] !== 1'b1 || st_rd[0] !== 1'b0 || st_data[0] !== 16'd100) begin
        errors++;
        $display("FAIL enq_strobe: cyc %0d wrt %b rd %b data %0d want cyc %0d 1 0 100",
                 st_cyc[0], st_wrt[0], st_rd[0], st_data[0], acc + 2);
      end
    end
    if (rs_cyc.size() == 1) begin
      checks++;
      if (rs_cyc[0] !== acc + 2 || rs_data[0] !== 16'd0 || rs_err[0] !== 1'b0) begin
        errors++;
        $display("FAIL enq_resp: cyc %0d data %0d err %b want cyc %0d 0 0", rs_cyc[0], rs_data[0], rs_err[0], acc + 2);
      end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int acc;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'd5; exp_d[1] = 16'd9; exp_d[2] = 16'd7;
    clr(); stalls = 0;
    for (int i = 0; i < 3; i++) send(2'd0, exp_d[i], acc);
    wait_resp(3);
    checks++;
    if (stalls !== 0) begin errors++; $display("FAIL b2b_s_ready: stalls got %0d want 0", stalls); end
    if (st_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (st_data[i] !== exp_d[i] || st_wrt[i] !== 1'b1) begin
          errors++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, st_data[i], exp_d[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (st_cyc[i] - st_cyc[i-1] !== 25) begin
          errors++; $display("FAIL b2b_gap[%0d]: got %0d want 25", i, st_cyc[i] - st_cyc[i-1]);
        end
      end
    end else begin
      checks++; errors++; $display("FAIL b2b_strobe_count: got %0d want 3", st_cyc.size());
    end
    checks++;
    if (rs_err[0] !== 1'b0 || rs_err[1] !== 1'b0 || rs_err[2] !== 1'b0 || rs_cyc[2] !== st_cyc[2]) begin
      errors++; $display("FAIL b2b_resp: last resp cyc %0d want %0d", rs_cyc[2], st_cyc[2]);
    end
    wait_idle();
  endtask

  task automatic test_deq_empty();
    int acc_d, acc_e;
    clr(); t_empty = 1'b1; t_full = 1'b0;
    send(2'd1, 16'd0, acc_d);
    send(2'd0, 16'd11, acc_e);
    wait_resp(2);
    checks++;
    if (rs_err[0] !== 1'b1 || rs_data[0] !== 16'd0 || rs_cyc[0] !== acc_d + 2) begin
      errors++; $display("FAIL deq_empty_resp: err %b data %0d cyc %0d want 1 0 %0d", rs_err[0], rs_data[0], rs_cyc[0], acc_d + 2);
    end
    checks++;
    if (st_cyc.size() !== 1) begin
      errors++; $display("FAIL deq_empty_strobes: got %0d want 1", st_cyc.size());
    end else begin
      checks++;
      if (st_cyc[0] !== acc_d + 4 || st_data[0] !== 16'd11 || st_wrt[0] !== 1'b1) begin
        errors++; $display("FAIL enq_after_reject: cyc %0d data %0d want cyc %0d data 11", st_cyc[0], st_data[0], acc_d + 4);
      end
    end
    checks++;
    if (rs_err[1] !== 1'b0) begin errors++; $display("FAIL enq_after_reject_err: got %b want 0", rs_err[1]); end
    wait_idle();
  endtask

  task automatic test_repl();
    int acc;
    clr(); t_empty = 1'b0; t_full = 1'b0; t_top = 16'd900;
    send(2'd2, 16'd42, acc);
    wait_resp(1);
    checks++;
    if (st_cyc.size() !== 1 || st_cyc[0] !== acc + 2 || st_wrt[0] !== 1'b1 || st_rd[0] !== 1'b1 || st_data[0] !== 16'd42) begin
      errors++; $display("FAIL repl_strobe: count %0d want 1 with wrt=read=1 data 42", st_cyc.size());
    end
    checks++;
    if (rs_data[0] !== 16'd900 || rs_err[0] !== 1'b0) begin
      errors++; $display("FAIL repl_resp: data %0d err %b want 900 0", rs_data[0], rs_err[0]);
    end
    wait_idle();
    clr(); t_top = 16'd0; t_empty = 1'b1;
    send(2'd2, 16'd3, acc);
    wait_resp(1);
    checks++;
    if (st_cyc.size() !== 1 || st_wrt[0] !== 1'b1 || st_rd[0] !== 1'b0 || st_data[0] !== 16'd3) begin
      errors++; $display("FAIL repl_empty_strobe: count %0d want 1 with wrt only data 3", st_cyc.size());
    end
    checks++;
    if (rs_data[0] !== 16'd0 || rs_err[0] !== 1'b0) begin
      errors++; $display("FAIL repl_empty_resp: data %0d err %b want 0 0", rs_data[0], rs_err[0]);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int acc, bad;
    logic [1:0]  ops  [5];
    logic [15:0] dats [5];
    logic [15:0] exp_r[5];
    ops[0] = 2'd1; ops[1] = 2'd0; ops[2] = 2'd0; ops[3] = 2'd1; ops[4] = 2'd0;
    dats[0] = 16'd0; dats[1] = 16'd21; dats[2] = 16'd22; dats[3] = 16'd0; dats[4] = 16'd23;
    exp_r[0] = 16'd77; exp_r[1] = 16'd0; exp_r[2] = 16'd0; exp_r[3] = 16'd55; exp_r[4] = 16'd0;
    clr(); stalls = 0; t_empty = 1'b0; t_full = 1'b0; t_top = 16'd77; r_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(ops[i], dats[i], acc);
    t_top = 16'd55;
    @(negedge CLK);
    checks++;
    if (s_ready !== 1'b0 || o_busy !== 1'b1 || stalls !== 0) begin
      errors++; $display("FAIL bp_full: s_ready %b o_busy %b stalls %0d want 0 1 0", s_ready, o_busy, stalls);
    end
    bad = 0;
    repeat (40) begin
      @(negedge CLK);
      if (!(r_valid === 1'b1 && r_data === 16'd77 && t_wrt === 1'b0 && t_read === 1'b0 && s_ready === 1'b0)) bad++;
    end
    @(posedge CLK); #1;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_hold: unstable cycles got %0d want 0", bad); end
    checks++;
    if (st_cyc.size() !== 1) begin errors++; $display("FAIL bp_strobes_held: got %0d want 1", st_cyc.size()); end
    r_ready = 1'b1;
    wait_resp(5);
    if (rs_cyc.size() == 5 && st_cyc.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rs_data[i] !== exp_r[i] || rs_err[i] !== 1'b0 || st_rd[i] !== (ops[i] == 2'd1) || st_data[i] !== dats[i]) begin
          errors++; $display("FAIL bp_drain[%0d]: r_data %0d want %0d, t_data %0d want %0d", i, rs_data[i], exp_r[i], st_data[i], dats[i]);
        end
      end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (st_cyc[i] - st_cyc[i-1] < 25) begin
          errors++; $display("FAIL bp_gap[%0d]: got %0d want >=25", i, st_cyc[i] - st_cyc[i-1]);
        end
      end
    end else begin
      checks++; errors++; $display("FAIL bp_drain_count: resp %0d strobes %0d want 5 5", rs_cyc.size(), st_cyc.size());
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_gap();
    int acc;
    clr(); t_empty = 1'b1; t_full = 1'b0;
    send(2'd0, 16'd8, acc);
    repeat (5) @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b want 1", o_busy); end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({s_ready, r_valid, r_err, t_wrt, t_read, o_busy} !== 6'b0 || r_data !== 16'd0 || t_data !== 16'd0) begin
      errors++; $display("FAIL mid_reset_outputs: flags got %b want 000000", {s_ready, r_valid, r_err, t_wrt, t_read, o_busy});
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (s_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_release: s_ready %b o_busy %b want 1 0", s_ready, o_busy);
    end
    @(posedge CLK); #1;
    clr();
    send(2'd0, 16'd12, acc);
    wait_resp(1);
    checks++;
    if (st_cyc.size() !== 1 || st_cyc[0] !== acc + 2 || st_data[0] !== 16'd12) begin
      errors++; $display("FAIL enq_after_reset: strobes %0d want 1 at cyc %0d data 12", st_cyc.size(), acc + 2);
    end
    wait_idle();
  endtask

  initial begin
    RST = 1'b1; s_valid = 1'b0; s_op = 2'd0; s_data = 16'd0; r_ready = 1'b1;
    t_full = 1'b0; t_empty = 1'b1; t_top = 16'd0;
    test_reset();
    test_enq_single();
    test_back_to_back();
    test_deq_empty();
    test_repl();
    test_backpressure();
    test_reset_mid_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
